// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one block-device bridge between NREQ sector requesters.
// Define SD_ARB_TIMEOUT_EN to build the REQ-state wait limit and the sticky timeout_err flag.
module sd_req_arbiter #(
  parameter int NREQ           = 3,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [32*NREQ-1:0]   req_lba,
  input  logic [8*NREQ-1:0]    req_buff_din,
  output logic [NREQ-1:0]      req_ack,
  output logic                 host_rd,
  output logic                 host_wr,
  output logic [31:0]          host_lba,
  output logic [1:0]           host_slot,
  input  logic                 host_ack,
  output logic [7:0]           buff_din,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_GAP} state_t;

  state_t          r_state, w_state_nx;
  logic [1:0]      r_owner, w_owner_nx;
  logic [1:0]      r_last, w_last_nx;
  logic [31:0]     r_lba, w_lba_nx;
  logic            r_rd, w_rd_nx;
  logic            r_wr, w_wr_nx;
  logic [NREQ-1:0] r_ack, w_ack_nx;
  logic [NREQ-1:0] w_pend;
  logic            w_found;
  logic [1:0]      w_pick;
  logic [1:0]      w_sel;
  logic            w_tmo;
  logic            w_terr_set;
  int              w_idx;

  assign w_pend = req_rd | req_wr;

  // First pending requester after last_grant, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_last) + k) % NREQ;
      if (!w_found && w_pend[w_idx]) begin
        w_found = 1'b1;
        w_pick  = 2'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_last_nx  = r_last;
    w_lba_nx   = r_lba;
    w_rd_nx    = r_rd;
    w_wr_nx    = r_wr;
    w_ack_nx   = r_ack;
    w_terr_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nx = w_pick;
          w_last_nx  = w_pick;
          w_lba_nx   = req_lba[32*w_pick +: 32];
          // read wins when a requester raises both strobes
          w_rd_nx    = req_rd[w_pick];
          w_wr_nx    = !req_rd[w_pick];
          w_state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (host_ack) begin
          w_rd_nx           = 1'b0;
          w_wr_nx           = 1'b0;
          w_ack_nx          = '0;
          w_ack_nx[r_owner] = 1'b1;
          w_state_nx        = S_XFER;
        end else if (w_tmo) begin
          // abort: one-cycle ack so the requester is not left waiting
          w_rd_nx           = 1'b0;
          w_wr_nx           = 1'b0;
          w_ack_nx          = '0;
          w_ack_nx[r_owner] = 1'b1;
          w_terr_set        = 1'b1;
          w_state_nx        = S_GAP;
        end
      end
      S_XFER: begin
        w_ack_nx          = '0;
        w_ack_nx[r_owner] = host_ack;
        if (!host_ack) w_state_nx = S_GAP;
      end
      S_GAP: begin
        w_ack_nx   = '0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_owner <= 2'd0;
      r_last  <= 2'(NREQ-1);
      r_lba   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_last  <= w_last_nx;
      r_lba   <= w_lba_nx;
      r_rd    <= w_rd_nx;
      r_wr    <= w_wr_nx;
      r_ack   <= w_ack_nx;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_terr;

  // Counts REQ cycles; held at zero elsewhere so every REQ entry starts fresh.
  assign w_tmo = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else begin
      r_cnt  <= (r_state == S_REQ) ? CW'(r_cnt + 1'b1) : '0;
      if (w_terr_set) r_terr <= 1'b1;
    end
  end

  assign timeout_err = r_terr;
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign busy      = (r_state != S_IDLE);
  assign w_sel     = busy ? r_owner : r_last;
  assign buff_din  = req_buff_din[8*w_sel +: 8];
  assign req_ack   = r_ack;
  assign host_rd   = r_rd;
  assign host_wr   = r_wr;
  assign host_lba  = r_lba;
  assign host_slot = r_owner;

endmodule

// File: doc/sd_req_arbiter.md
# sd_req_arbiter

Shares the core's single block-device bridge between the sector requesters: floppy_track drive 1, the HDD controller and floppy_track drive 2. Each requester keeps its own sd_rd/sd_wr/sd_lba/sd_ack handshake, and exactly one transfer reaches the bridge at a time. The block picks requesters round-robin, latches the LBA and operation, and routes the bridge acknowledge back to the owner. It also muxes the owner's buffer data (sd_buff_din) toward the bridge. It sits between the requesters and the data-slot bridge in the top level.

## Interface
Parameters:
- NREQ, 3: number of requesters. Index 0 is drive 1, index 1 is the HDD, index 2 is drive 2.
- TIMEOUT_CYCLES, 1048576: REQ-state wait limit. Used only with SD_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  core clock (14.318 MHz pixel clock domain); all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_rd  in  NREQ  level read request per requester. Held by the requester until its req_ack rises.
- req_wr  in  NREQ  level write request per requester, same rule as req_rd.
- req_lba  in  32*NREQ  packed sector address; requester i occupies bits [32i+31:32i].
- req_buff_din  in  8*NREQ  packed write data from each requester's track/sector buffer.
- req_ack  out  NREQ  per-requester acknowledge. Only the owner's bit is ever high.
- host_rd  out  1  read strobe to the bridge.
- host_wr  out  1  write strobe to the bridge.
- host_lba  out  32  latched LBA of the granted transfer.
- host_slot  out  2  index of the owner.
- host_ack  in  1  bridge acknowledge; high for the duration of the data transfer.
- buff_din  out  8  req_buff_din of the current owner, combinational mux on the owner register.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky timeout flag.

## Operation
- The state machine has four states: IDLE, REQ, XFER and GAP.
- IDLE:
  - Requester i is pending when req_rd[i] | req_wr[i].
  - Search starts at last_grant+1 and wraps modulo NREQ. The first pending index wins.
  - On a grant, latch owner, lba = req_lba[owner] and op. If both rd and wr are set, op = read.
  - Set last_grant to the owner, go to REQ, and assert host_rd or host_wr per op.
- REQ:
  - Hold host_rd/host_wr, host_lba and host_slot stable.
  - On the first cycle host_ack is sampled high: clear host_rd/host_wr, set req_ack[owner]=1, go to XFER.
- XFER:
  - req_ack[owner] is the registered copy of host_ack.
  - When host_ack is sampled low: req_ack[owner]=0, go to GAP.
- GAP: one cycle, then IDLE. This gives the requester one cycle to drop its request before re-arbitration.
- A granted transfer is committed. If the requester withdraws req_rd/req_wr after the grant, the transfer still completes and req_ack still pulses.
- Requests arriving in any state other than IDLE wait. Nothing is queued beyond the requester's own level request.
- host_lba and host_slot keep their last values in IDLE.
- buff_din is valid whenever busy=1. In IDLE it shows requester last_grant.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: host_rd/host_wr=0, host_lba=0, host_slot=0, req_ack=0, busy=0, timeout_err=0.
  - Internal: state=IDLE, last_grant=NREQ-1, so requester 0 is first after reset.
- Reset asserted mid-REQ or mid-XFER abandons the transfer. Recovering the bridge is the top level's responsibility; dd_reset covers both sides.
- Grant latency: a request visible at edge t gives host_rd/host_wr=1 and busy=1 after edge t+1.
- Acknowledge latency: host_ack rises at edge t; req_ack[owner] rises and host_rd falls after edge t+1. Falling edges are also delayed by one cycle.
- Back-to-back: if host_ack falls at edge t, the next host strobe rises no earlier than edge t+3 (XFER to GAP, GAP to IDLE, IDLE to REQ).
- A host_ack that is high for one cycle still produces a one-cycle req_ack.

## Configuration
- SD_ARB_TIMEOUT_EN defined:
  - A counter runs in REQ only, cleared on entry.
  - When it reaches TIMEOUT_CYCLES with host_ack still low: host_rd/host_wr drop, req_ack[owner] pulses for exactly one cycle, timeout_err sets, and the FSM goes to GAP.
  - timeout_err clears only on reset.
- SD_ARB_TIMEOUT_EN not defined: REQ waits indefinitely, the counter is not built, and timeout_err is tied 0.

## Test plan
- Single HDD read: req_rd=3'b010, req_lba[1]=0x00001234, host_ack high 512 cycles → host_rd=1, host_slot=1, host_lba=0x1234 one cycle after the request. req_ack=3'b010 for 512 cycles, delayed one cycle from host_ack.
- Fairness: all three req_rd held high after reset, bridge acking each in 4 cycles → grant order 0,1,2,0,1. No requester is granted twice in a row.
- Write data path: req_wr[2]=1 with req_buff_din[2]=0xA5 and the others 0x00 → host_wr=1, host_rd=0, buff_din=0xA5 throughout XFER.
- Read priority: req_rd[0]=req_wr[0]=1 → only host_rd asserts, and host_wr stays 0.
- Reset mid-XFER: reset_n low during host_ack=1 → all outputs 0 in the same cycle. After release, req_rd[2] alone is granted with host_slot=2.
- Timeout (SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): host_ack never rises → host_rd drops 16 cycles after REQ entry, req_ack[owner] pulses one cycle, timeout_err=1 until reset.
